// File: rtl/conv_core.sv
// 1-D convolution engine: Z[i] = sum_j X[j]*Y[i-j], one output per SETUP/READ/DRAIN/WRITE pass.
// X/Y memories have one cycle of read latency; results are written one word per output index.
module conv_core #(
  parameter int DATAWIDTH = 32,
  parameter int MAX_SIZE  = 32
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 en_s,
  input  logic                 start,
  input  logic [5:0]           size_x,
  input  logic [5:0]           size_y,
  output logic [4:0]           mem_x_addr,
  input  logic [7:0]           mem_x_data,
  output logic [4:0]           mem_y_addr,
  input  logic [7:0]           mem_y_data,
  output logic [5:0]           mem_z_addr,
  output logic [DATAWIDTH-1:0] mem_z_data,
  output logic                 mem_z_we,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [5:0]           sx_q, sx_d, sy_q, sy_d, i_q, i_d;
  logic [4:0]           jhi_q, jhi_d, x_addr_q, x_addr_d, y_addr_q, y_addr_d;
  logic [20:0]          acc_q, acc_d;
  logic                 acc_en_q, acc_en_d;
  logic [15:0]          hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic [5:0]           z_addr_q, z_addr_d;
  logic [DATAWIDTH-1:0] z_data_q, z_data_d;
  logic                 z_we_q, z_we_d, busy_q, busy_d, done_q, done_d;

  logic [15:0] prod_s;
  logic [6:0]  ip1_s, sy7_s, last_s;
  logic [4:0]  jlo_s, jhi_s;
  logic [5:0]  size_x_s, size_y_s;

  assign prod_s   = 16'(mem_x_data) * 16'(mem_y_data);
  assign ip1_s    = {1'b0, i_q} + 7'd1;
  assign sy7_s    = {1'b0, sy_q};
  assign last_s   = {1'b0, sx_q} + {1'b0, sy_q} - 7'd2;
  assign jlo_s    = (ip1_s > sy7_s) ? 5'(ip1_s - sy7_s) : 5'd0;
  assign jhi_s    = (i_q < sx_q) ? 5'(i_q) : 5'(sx_q - 6'd1);
  assign size_x_s = (size_x > 6'(MAX_SIZE)) ? 6'(MAX_SIZE) : size_x;
  assign size_y_s = (size_y > 6'(MAX_SIZE)) ? 6'(MAX_SIZE) : size_y;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    i_d        = i_q;
    jhi_d      = jhi_q;
    x_addr_d   = x_addr_q;
    y_addr_d   = y_addr_q;
    acc_d      = acc_q;
    acc_en_d   = acc_en_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    z_addr_d   = z_addr_q;
    z_data_d   = z_data_q;
    z_we_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (en_s) begin
      acc_en_d   = (state_q == READ);
      hold_vld_d = 1'b0;
      // A product that arrived while frozen was parked in hold_q; use it on resume.
      if (acc_en_q) begin
        acc_d = acc_q + 21'(hold_vld_q ? hold_q : prod_s);
      end else begin
        acc_d = acc_q;
      end
      done_d = (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            sx_d = size_x_s;
            sy_d = size_y_s;
            i_d  = 6'd0;
            if ((size_x_s == 6'd0) || (size_y_s == 6'd0)) begin
              state_d = DONE;
            end else begin
              state_d = SETUP;
            end
          end else begin
            state_d = IDLE;
          end
        end
        SETUP: begin
          acc_d    = 21'd0;
          jhi_d    = jhi_s;
          x_addr_d = jlo_s;
          y_addr_d = 5'(i_q - {1'b0, jlo_s});
          state_d  = READ;
        end
        READ: begin
          if (x_addr_q == jhi_q) begin
            x_addr_d = 5'd0;
            y_addr_d = 5'd0;
            state_d  = DRAIN;
          end else begin
            x_addr_d = x_addr_q + 5'd1;
            y_addr_d = y_addr_q - 5'd1;
            state_d  = READ;
          end
        end
        DRAIN: begin
          z_we_d   = 1'b1;
          z_addr_d = i_q;
          z_data_d = DATAWIDTH'(acc_d);
          state_d  = WRITE;
        end
        WRITE: begin
          if ({1'b0, i_q} == last_s) begin
            state_d = DONE;
          end else begin
            i_d     = i_q + 6'd1;
            state_d = SETUP;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      busy_d = (state_d != IDLE);
    end else begin
      // Memory data keeps moving while frozen, so capture the in-flight product once.
      if (acc_en_q && !hold_vld_q) begin
        hold_d     = prod_s;
        hold_vld_d = 1'b1;
      end else begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
      end
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q    <= IDLE;
      sx_q       <= 6'd0;
      sy_q       <= 6'd0;
      i_q        <= 6'd0;
      jhi_q      <= 5'd0;
      x_addr_q   <= 5'd0;
      y_addr_q   <= 5'd0;
      acc_q      <= 21'd0;
      acc_en_q   <= 1'b0;
      hold_q     <= 16'd0;
      hold_vld_q <= 1'b0;
      z_addr_q   <= 6'd0;
      z_data_q   <= '0;
      z_we_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      i_q        <= i_d;
      jhi_q      <= jhi_d;
      x_addr_q   <= x_addr_d;
      y_addr_q   <= y_addr_d;
      acc_q      <= acc_d;
      acc_en_q   <= acc_en_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      z_addr_q   <= z_addr_d;
      z_data_q   <= z_data_d;
      z_we_q     <= z_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_x_addr = x_addr_q;
  assign mem_y_addr = y_addr_q;
  assign mem_z_addr = z_addr_q;
  assign mem_z_data = z_data_q;
  assign mem_z_we   = z_we_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_conv_core.sv
// Directed bench for conv_core: memory models, a reference convolution feeding a
// scoreboard queue, and a write monitor that pops and compares each Z write.
module tb_conv_core;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        en_s = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  size_x = 6'd0;
  logic [5:0]  size_y = 6'd0;
  logic [4:0]  mem_x_addr, mem_y_addr;
  logic [7:0]  mem_x_data = 8'd0;
  logic [7:0]  mem_y_data = 8'd0;
  logic [5:0]  mem_z_addr;
  logic [31:0] mem_z_data;
  logic        mem_z_we, busy, done;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } zexp_t;

  zexp_t       sb_q[$];
  zexp_t       pop_e;
  logic [7:0]  xmem[32];
  logic [7:0]  ymem[32];
  logic [31:0] zmem[64];
  logic [7:0]  ybasic[15] = '{8'h2D, 8'h29, 8'hA6, 8'h2F, 8'h4A, 8'hEB, 8'h73, 8'h5B,
                              8'h02, 8'hFB, 8'h71, 8'h5F, 8'h61, 8'h09, 8'h13};
  int n_vec = 0;
  int n_err = 0;
  int n_writes = 0;

  conv_core #(.DATAWIDTH(32), .MAX_SIZE(32)) dut (
    .clk(clk), .rst_a(rst_a), .en_s(en_s), .start(start),
    .size_x(size_x), .size_y(size_y),
    .mem_x_addr(mem_x_addr), .mem_x_data(mem_x_data),
    .mem_y_addr(mem_y_addr), .mem_y_data(mem_y_data),
    .mem_z_addr(mem_z_addr), .mem_z_data(mem_z_data), .mem_z_we(mem_z_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read X/Y memories: data follows the address by one cycle
  always @(posedge clk) begin
    mem_x_data <= xmem[mem_x_addr];
    mem_y_data <= ymem[mem_y_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every Z write must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_a === 1'b1 && mem_z_we === 1'b1) begin
      n_writes++;
      zmem[mem_z_addr] = mem_z_data;
      n_vec++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL z_extra_write: observed write to %0d expected none", mem_z_addr);
      end
      if (sb_q.size() != 0) begin
        pop_e = sb_q.pop_front();
        chk("z_addr", {26'd0, mem_z_addr}, {26'd0, pop_e.addr});
        chk("z_data", mem_z_data, pop_e.data);
      end
    end
  end

  task automatic push_expected(input int sx, input int sy);
    zexp_t e;
    if (sx > 0 && sy > 0) begin
      for (int i = 0; i < sx + sy - 1; i++) begin
        int s = 0;
        for (int j = 0; j < sx; j++) begin
          if (i - j >= 0 && i - j < sy) s += int'(xmem[j]) * int'(ymem[i - j]);
        end
        e.addr = 6'(i);
        e.data = 32'(s);
        sb_q.push_back(e);
      end
    end
  endtask

  // One full run; done is expected one cycle after the DONE state, which itself
  // is reached sx*sy + 3*(sx+sy-1) cycles after the acceptance edge.
  task automatic run_conv(input int sx, input int sy, input int stray_at,
                          input int freeze_at, input int freeze_len);
    int cnt = 0;
    int t_run;
    int wr0;
    for (int k = 0; k < 64; k++) zmem[k] = 32'hDEAD_BEEF;
    push_expected(sx, sy);
    t_run = (sx == 0 || sy == 0) ? 0 : sx * sy + 3 * (sx + sy - 1);
    wr0 = n_writes;
    @(negedge clk);
    size_x = 6'(sx);
    size_y = 6'(sy);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    size_x = 6'd3;
    size_y = 6'd9;
    while (cnt < 5000) begin
      start = (cnt == stray_at) ? 1'b1 : 1'b0;
      en_s  = (freeze_len > 0 && cnt >= freeze_at && cnt < freeze_at + freeze_len) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      cnt++;
      if (en_s == 1'b0) chk("freeze_quiet", {30'd0, done, mem_z_we}, 32'd0);
      if (done === 1'b1) break;
    end
    start = 1'b0;
    en_s  = 1'b1;
    chk("done_latency", cnt, t_run + 1 + freeze_len);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("write_count", n_writes - wr0, (sx == 0 || sy == 0) ? 0 : sx + sy - 1);
    chk("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    int found;
    for (int k = 0; k < 32; k++) begin
      xmem[k] = 8'd0;
      ymem[k] = 8'd0;
    end
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_we", {31'd0, mem_z_we}, 32'd0);
    chk("rst_xaddr", {27'd0, mem_x_addr}, 32'd0);
    chk("rst_zdata", mem_z_data, 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    en_s  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_no_start", {31'd0, busy}, 32'd0);

    // Basic case
    for (int k = 0; k < 5; k++) xmem[k] = 8'(k + 1);
    for (int k = 0; k < 15; k++) ymem[k] = ybasic[k];
    run_conv(5, 15, -1, -1, 0);
    chk("basic_z0", zmem[0], 32'h2D);
    chk("basic_z1", zmem[1], 32'h83);

    // Start while busy, then enable freeze mid-READ
    run_conv(5, 15, 40, -1, 0);
    chk("stray_z1", zmem[1], 32'h83);
    run_conv(5, 15, -1, 17, 10);
    chk("freeze_z1", zmem[1], 32'h83);

    // Zero length
    run_conv(5, 0, -1, -1, 0);

    // Maximum case
    for (int k = 0; k < 32; k++) begin
      xmem[k] = 8'hFF;
      ymem[k] = 8'hFF;
    end
    run_conv(32, 32, -1, -1, 0);
    chk("max_z31", zmem[31], 32'h1FC020);
    chk("max_z0", zmem[0], 32'hFE01);
    chk("max_z62", zmem[62], 32'hFE01);

    // Random data, uneven sizes
    for (int k = 0; k < 32; k++) begin
      xmem[k] = 8'($urandom_range(255));
      ymem[k] = 8'($urandom_range(255));
    end
    run_conv(7, 3, -1, -1, 0);
    run_conv(1, 1, -1, -1, 0);

    // Reset during the WRITE of Z[7]
    for (int k = 0; k < 5; k++) xmem[k] = 8'(k + 1);
    for (int k = 0; k < 15; k++) ymem[k] = ybasic[k];
    push_expected(5, 15);
    @(negedge clk);
    size_x = 6'd5;
    size_y = 6'd15;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      #1;
      if (mem_z_we === 1'b1 && mem_z_addr === 6'd7) begin
        found = 1;
        break;
      end
    end
    chk("rst_write7_seen", found, 1);
    rst_a = 1'b0;
    #1;
    chk("midrst_we", {31'd0, mem_z_we}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_zaddr", {26'd0, mem_z_addr}, 32'd0);
    chk("midrst_zdata", mem_z_data, 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    run_conv(5, 15, -1, -1, 0);
    chk("post_rst_z0", zmem[0], 32'h2D);
    chk("post_rst_z7", zmem[7], 32'(int'(xmem[0]) * int'(ymem[7]) + int'(xmem[1]) * int'(ymem[6])
                                  + int'(xmem[2]) * int'(ymem[5]) + int'(xmem[3]) * int'(ymem[4])
                                  + int'(xmem[4]) * int'(ymem[3])));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
